// File: rtl/booth_multiplier_param.sv
// -----------------------------------------------------------------------------
// booth_multiplier_param
//
// Iterative radix-2 Booth multiplier with a WIDTH parameter and a
// signed/unsigned mode. One Booth step per clock, WIDTH+1 steps per operation.
// The result is ready WIDTH+1 clocks after the start edge and returns the full
// double-width product and an overflow flag.
//
// Ports:
//   clk            - system clock, rising edge
//   reset_n        - synchronous active-low reset
//   ctrl_mult      - start pulse; restarts the unit from any state
//   mult_signed    - 1 = two's-complement operands, 0 = unsigned (latched)
//   multiplicand   - operand A (latched on start)
//   multiplier     - operand B (latched on start)
//   out            - low WIDTH bits of the last completed product
//   out_hi         - high WIDTH bits of the last completed product
//   data_resultRDY - one-cycle pulse when out/out_hi/data_exception update
//   data_exception - product does not fit in WIDTH bits (held with out)
//   busy           - an operation is in progress
// -----------------------------------------------------------------------------
module booth_multiplier_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_mult,
  input  logic             mult_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    step;
  logic [WIDTH:0]   hi;          // upper accumulator half
  logic [WIDTH:0]   lo;          // lower accumulator half, starts as multiplier
  logic             q_m1;        // Booth look-behind bit
  logic [WIDTH:0]   mcand;       // latched, extended multiplicand
  logic             mode;        // latched signed/unsigned mode

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   mplier_ext;
  logic [WIDTH:0]   hi_sum;
  logic [WIDTH-1:0] prod_lo;
  logic [WIDTH-1:0] prod_hi;
  logic             ovf;

  // One extra bit lets unsigned operands run through the same signed Booth
  // recoding: zero-extension keeps them positive.
  assign mcand_ext  = {mult_signed & multiplicand[WIDTH-1], multiplicand};
  assign mplier_ext = {mult_signed & multiplier[WIDTH-1],   multiplier};

  always_comb begin
    // NOTE: default assignment first so every path drives hi_sum and no latch is inferred.
    hi_sum = hi;
    case ({lo[0], q_m1})
      2'b01:   hi_sum = hi + mcand;
      2'b10:   hi_sum = hi - mcand;
      default: hi_sum = hi;
    endcase
  end

  // Product as it will stand after the shift of the current step: the low
  // 2*WIDTH bits of {hi, lo} are {hi_sum[WIDTH-1:0], lo[WIDTH:1]}.
  assign prod_lo = lo[WIDTH:1];
  assign prod_hi = hi_sum[WIDTH-1:0];
  assign ovf     = mode ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}})
                        : (prod_hi != '0);

  // NOTE: all state below is sequential, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      step           <= '0;
      hi             <= '0;
      lo             <= '0;
      q_m1           <= 1'b0;
      mcand          <= '0;
      mode           <= 1'b0;
      out            <= '0;
      out_hi         <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_mult) begin
        // Start or restart from any state; results of the aborted
        // operation are simply never registered.
        state <= RUN;
        step  <= '0;
        hi    <= '0;
        lo    <= mplier_ext;
        q_m1  <= 1'b0;
        mcand <= mcand_ext;
        mode  <= mult_signed;
        busy  <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            hi   <= {hi_sum[WIDTH], hi_sum[WIDTH:1]};
            lo   <= {hi_sum[0], lo[WIDTH:1]};
            q_m1 <= lo[0];
            if (step == LAST_STEP) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              out            <= prod_lo;
              out_hi         <= prod_hi;
              data_exception <= ovf;
            end else begin
              step <= step + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_param.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier_param
//
// Directed bench for booth_multiplier_param: a WIDTH=32 instance for the
// documented vectors, restart, back-to-back, held start and reset, and a
// WIDTH=8 instance swept over corner and random operand pairs against an
// arithmetic reference product.
// -----------------------------------------------------------------------------
module tb_booth_multiplier_param;

  logic clk = 1'b0;
  logic reset_n;

  logic        s_ctrl, s_sgn, s_rdy, s_ex, s_busy;
  logic [31:0] s_a, s_b, s_out, s_hi;

  logic        e_ctrl, e_sgn, e_rdy, e_ex, e_busy;
  logic [7:0]  e_a, e_b, e_out, e_hi;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_multiplier_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .ctrl_mult(s_ctrl), .mult_signed(s_sgn),
    .multiplicand(s_a), .multiplier(s_b), .out(s_out), .out_hi(s_hi),
    .data_resultRDY(s_rdy), .data_exception(s_ex), .busy(s_busy)
  );

  booth_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .ctrl_mult(e_ctrl), .mult_signed(e_sgn),
    .multiplicand(e_a), .multiplier(e_b), .out(e_out), .out_hi(e_hi),
    .data_resultRDY(e_rdy), .data_exception(e_ex), .busy(e_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges (sampled 1 time unit after) until ready, bounded.
  task automatic wait_rdy32(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!s_rdy && n < 100);
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [31:0] exp_lo,
                       input logic [31:0] exp_hi, input logic exp_ex);
    int n;
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = sgn; s_a = a; s_b = b;
    @(posedge clk); #1;
    check({tag, " busy_after_start"}, 64'(s_busy), 64'd1);
    @(negedge clk);
    s_ctrl = 1'b0; s_a = $urandom; s_b = $urandom; s_sgn = ~sgn;
    wait_rdy32(n);
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " product"}, {s_hi, s_out}, {exp_hi, exp_lo});
    check({tag, " exception"}, 64'(s_ex), 64'(exp_ex));
    check({tag, " busy_at_done"}, 64'(s_busy), 64'd0);
    @(posedge clk); #1;
    check({tag, " rdy_one_cycle"}, 64'(s_rdy), 64'd0);
    check({tag, " product_held"}, {s_hi, s_out}, {exp_hi, exp_lo});
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int n, nb;
    logic [15:0] p;
    logic        ex;
    if (sgn) p = 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
    else     p = {8'd0, a} * {8'd0, b};
    ex = sgn ? (p[15:8] != {8{p[7]}}) : (p[15:8] != 8'd0);
    @(negedge clk);
    e_ctrl = 1'b1; e_sgn = sgn; e_a = a; e_b = b;
    @(posedge clk); #1;
    nb = e_busy ? 1 : 0;
    @(negedge clk);
    e_ctrl = 1'b0; e_a = 8'($urandom); e_b = 8'($urandom); e_sgn = ~sgn;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (e_busy) nb++;
    end while (!e_rdy && n < 40);
    check("w8 latency", 64'(n), 64'd9);
    check("w8 busy_cycles", 64'(nb), 64'd9);
    check("w8 product", 64'({e_hi, e_out}), 64'(p));
    check("w8 exception", 64'(e_ex), 64'(ex));
  endtask

  logic [7:0] corners [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h55};

  initial begin
    int n, seen;
    reset_n = 1'b0;
    s_ctrl = 1'b0; s_sgn = 1'b0; s_a = '0; s_b = '0;
    e_ctrl = 1'b0; e_sgn = 1'b0; e_a = '0; e_b = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset product32", {s_hi, s_out}, 64'd0);
    check("reset ctrl32", {61'd0, s_rdy, s_ex, s_busy}, 64'd0);
    check("reset product8", 64'({e_hi, e_out}), 64'd0);
    check("reset ctrl8", {61'd0, e_rdy, e_ex, e_busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed WIDTH=32 vectors
    run32("s 7x-3",        32'd7,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    run32("s maxx2",       32'h7FFFFFFF, 32'd2,        1'b1, 32'hFFFFFFFE, 32'h00000000, 1'b1);
    run32("s minx-1",      32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'h00000000, 1'b1);
    run32("u ffxff",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    run32("s -1x-1",       32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'h00000000, 1'b0);
    run32("u 12345678x10", 32'h12345678, 32'h10,       1'b0, 32'h23456780, 32'h00000001, 1'b1);
    run32("u 80000000x2",  32'h80000000, 32'd2,        1'b0, 32'h00000000, 32'h00000001, 1'b1);
    run32("s -1x5",        32'hFFFFFFFF, 32'd5,        1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    run32("s 0xmin",       32'd0,        32'h80000000, 1'b1, 32'h00000000, 32'h00000000, 1'b0);

    // Restart at E10: only the second operation completes, 33 edges later
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = 1'b0; s_a = 32'd5; s_b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    s_ctrl = 1'b0;
    seen = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      if (s_rdy) seen++;
    end
    @(negedge clk);
    s_ctrl = 1'b1; s_a = 32'd3; s_b = 32'd4;
    @(posedge clk); #1;
    if (s_rdy) seen++;
    check("restart busy", 64'(s_busy), 64'd1);
    @(negedge clk);
    s_ctrl = 1'b0;
    wait_rdy32(n);
    check("restart latency", 64'(n), 64'd33);
    check("restart early_rdy", 64'(seen), 64'd0);
    check("restart product", {s_hi, s_out}, 64'd12);
    check("restart exception", 64'(s_ex), 64'd0);

    // Start held high for three edges: the last sample wins
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = 1'b0; s_a = 32'd1; s_b = 32'd1;
    @(negedge clk);
    s_a = 32'd2;
    @(negedge clk);
    s_sgn = 1'b1; s_a = 32'hFFFFFFFF; s_b = 32'd5;
    @(negedge clk);
    s_ctrl = 1'b0;
    wait_rdy32(n);
    check("held latency", 64'(n), 64'd33);
    check("held product", {s_hi, s_out}, 64'hFFFFFFFF_FFFFFFFB);

    // Back-to-back: start in the DONE cycle
    run32("b2b first", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    check("b2b idle", 64'(s_busy), 64'd0);
    // A second run straight into DONE: wait for ready then restart immediately
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = 1'b0; s_a = 32'd9; s_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    s_ctrl = 1'b0;
    wait_rdy32(n);
    check("b2b a latency", 64'(n), 64'd33);
    check("b2b a product", {s_hi, s_out}, 64'd81);
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = 1'b1; s_a = 32'h7FFFFFFF; s_b = 32'd2;
    @(posedge clk); #1;
    check("b2b rdy_falls", 64'(s_rdy), 64'd0);
    check("b2b busy", 64'(s_busy), 64'd1);
    check("b2b held", {s_hi, s_out}, 64'd81);
    @(negedge clk);
    s_ctrl = 1'b0;
    wait_rdy32(n);
    check("b2b b latency", 64'(n), 64'd33);
    check("b2b b product", {s_hi, s_out}, 64'h00000000_FFFFFFFE);
    check("b2b b exception", 64'(s_ex), 64'd1);

    // Reset at E20 of a running operation, asserted together with a start
    @(negedge clk);
    s_ctrl = 1'b1; s_sgn = 1'b1; s_a = 32'd7; s_b = 32'hFFFFFFFD;
    @(posedge clk);
    @(negedge clk);
    s_ctrl = 1'b0;
    repeat (18) @(negedge clk);
    reset_n = 1'b0; s_ctrl = 1'b1;
    @(posedge clk); #1;
    check("reset mid product", {s_hi, s_out}, 64'd0);
    check("reset mid ctrl", {61'd0, s_rdy, s_ex, s_busy}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1; s_ctrl = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (s_rdy || s_busy) seen++;
    end
    check("reset no_activity", 64'(seen), 64'd0);

    // WIDTH=8 corner sweep in both modes, then random pairs
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          run8(corners[i], corners[j], m[0]);
    for (int k = 0; k < 100; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
